game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Parametrised game-flow controller for the Snake top level.
- Replaces the fixed-rate step tick and the ad-hoc game_over latch with one block containing:
  - a phase-accumulator step generator whose rate rises with level;
  - a game state machine: IDLE, RUN, PAUSE, DYING, OVER;
  - a lives counter and start/pause button handling.
- Drives tick_run into the snake core, and game_reset / round_restart into the core, score and apple blocks.

Parameters:
- CLK_HZ, 25_000_000, pixel clock frequency in Hz.
- BASE_HZ, 5, step rate at level 0.
- STEP_HZ, 1, step-rate increase per level.
- MAX_HZ, 15, step-rate ceiling.
- POINTS_PER_LEVEL, 5, accepted eat_evt pulses per level-up.
- LIVES, 3, lives per game (1..7).
- DEATH_STEPS, 10, internal steps the snake stays frozen after losing a life.
- LEVEL_W, 4, width of the level output.

Ports:
- clk_pix  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_btn_n  in  1  raw active-low start button, already debounced, asynchronous to clk_pix.
- pause_btn_n  in  1  raw active-low pause button, already debounced, asynchronous.
- eat_evt  in  1  single-cycle pulse: apple eaten.
- self_hit  in  1  level: head overlaps body.
- wall_hit  in  1  level: head in border.
- tick_run  out  1  single-cycle pulse: advance snake one step.
- game_reset  out  1  single-cycle pulse: new game; clear core, score and apple.
- round_restart  out  1  single-cycle pulse: respawn snake after a lost life; score is kept.
- state  out  3  IDLE=0, RUN=1, PAUSE=2, DYING=3, OVER=4.
- lives_left  out  3  remaining lives.
- level  out  LEVEL_W  current speed level.
- game_over  out  1  high in OVER.

Behaviour:
- Reset is asynchronous, active-low. Values while reset is asserted:
  - state=IDLE, lives_left=LIVES, level=0, eat counter=0;
  - accumulator=0, synchroniser flops=1;
  - tick_run, game_reset, round_restart and game_over all 0.
- Reset asserted mid-game aborts immediately to these values; no pulse is emitted.
- Buttons:
  - each button passes through a 2-FF synchroniser, then a falling-edge detector;
  - the press pulse (start_p / pause_p) is 1 cycle wide and occurs 3 cycles after the pin falls;
  - holding a button produces only one pulse.
- Step generator:
  - MAX_LEVEL = (MAX_HZ - BASE_HZ) / STEP_HZ.
  - rate = BASE_HZ + level*STEP_HZ, with level saturating at MAX_LEVEL.
  - The accumulator runs only in RUN and DYING. Each such cycle:
    - if acc + rate >= CLK_HZ: step=1 and acc <= acc + rate - CLK_HZ;
    - otherwise acc <= acc + rate.
  - The accumulator holds its value in PAUSE, and is cleared on game_reset and round_restart.
  - tick_run is step registered; it is 1 only when state==RUN in the same cycle.
- State transitions. Priority within a cycle: hit > pause > eat.
  - IDLE:
    - start_p: game_reset=1 next cycle; go to RUN.
    - pause_p is ignored.
  - RUN, when (self_hit | wall_hit):
    - if lives_left > 1: decrement lives_left; go to DYING with death counter = 0.
    - otherwise: lives_left = 0; go to OVER.
    - Any eat_evt in the same cycle is ignored.
  - RUN, otherwise:
    - pause_p: go to PAUSE.
    - eat_evt: increment the eat counter. When it reaches POINTS_PER_LEVEL, reset it to 0 and increment level, saturating at MAX_LEVEL.
  - PAUSE:
    - pause_p: go to RUN.
    - start_p, eat_evt and hits are ignored.
  - DYING:
    - tick_run is suppressed; each step increments the death counter.
    - When the counter reaches DEATH_STEPS: round_restart=1 for 1 cycle; go to RUN.
    - level is kept; pause_p is ignored.
  - OVER:
    - game_over=1.
    - start_p: game_reset=1, lives_left=LIVES, level=0, eat counter=0; go to RUN.
- eat_evt is ignored outside RUN.
- game_reset and round_restart never assert in the same cycle.

Test Plan (CLK_HZ=100, BASE_HZ=10, STEP_HZ=5, MAX_HZ=20, POINTS_PER_LEVEL=2, LIVES=2, DEATH_STEPS=3):
- Reset, then drop start_btn_n -> game_reset pulses exactly once; state=1; tick_run pulses every 10 cycles; holding the button gives no second game_reset.
- 2 eat_evt -> level=1, tick intervals 7,7,6 repeating. 4 eat_evt -> level=2, interval 5. 6 eat_evt -> level stays 2, interval 5.
- Pause press in RUN -> state=2, no tick_run, accumulator frozen. Second press -> RUN; the next tick arrives after the remaining interval, not a full one.
- self_hit in RUN with lives 2 -> lives_left=1, state=3, no tick_run for 3 steps, then round_restart for 1 cycle and state=1, level unchanged. A simultaneous eat_evt does not bump the eat counter.
- Second wall_hit -> lives_left=0, state=4, game_over=1, tick_run stuck at 0. Start press -> game_reset, lives_left=2, level=0, state=1.
- Assert reset_n low asynchronously mid-RUN -> all outputs return to their reset values without a clock edge; no stray pulse after release.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the Snake top level: level-scaled step generator,
// IDLE/RUN/PAUSE/DYING/OVER state machine, lives counter and button handling.
module game_flow_ctrl #(
  parameter int unsigned CLK_HZ           = 25_000_000,
  parameter int unsigned BASE_HZ          = 5,
  parameter int unsigned STEP_HZ          = 1,
  parameter int unsigned MAX_HZ           = 15,
  parameter int unsigned POINTS_PER_LEVEL = 5,
  parameter int unsigned LIVES            = 3,
  parameter int unsigned DEATH_STEPS      = 10,
  parameter int unsigned LEVEL_W          = 4
) (
  input  logic               clk_pix,
  input  logic               reset_n,
  input  logic               start_btn_n,
  input  logic               pause_btn_n,
  input  logic               eat_evt,
  input  logic               self_hit,
  input  logic               wall_hit,
  output logic               tick_run,
  output logic               game_reset,
  output logic               round_restart,
  output logic [2:0]         state,
  output logic [2:0]         lives_left,
  output logic [LEVEL_W-1:0] level,
  output logic               game_over
);

  localparam int unsigned MaxLevel = (MAX_HZ - BASE_HZ) / STEP_HZ;
  localparam int unsigned EatW     = $clog2(POINTS_PER_LEVEL + 1);
  localparam int unsigned DieW     = $clog2(DEATH_STEPS + 1);

  localparam logic [EatW-1:0]    EatTop    = EatW'(POINTS_PER_LEVEL);
  localparam logic [DieW-1:0]    DieTop    = DieW'(DEATH_STEPS);
  localparam logic [LEVEL_W-1:0] LevelTop  = LEVEL_W'(MaxLevel);
  localparam logic [2:0]         LivesInit = 3'(LIVES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StDying = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e             state_q;
  logic [2:0]         lives_q;
  logic [LEVEL_W-1:0] level_q;
  logic [EatW-1:0]    eat_cnt_q;
  logic [DieW-1:0]    death_cnt_q;
  logic [31:0]        acc_q;
  logic               tick_run_q;
  logic               game_reset_q;
  logic               round_restart_q;
  logic               game_over_q;

  // [0],[1] form the synchroniser; [2] is the previous synchronised level
  logic [2:0]         start_sync_q;
  logic [2:0]         pause_sync_q;

  logic               start_p;
  logic               pause_p;
  logic               hit;
  logic               running;
  logic               step;
  logic [31:0]        rate;
  logic [31:0]        acc_sum;
  logic [31:0]        acc_next;

  // Synchronise the asynchronous buttons and keep one extra stage for edge detection
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      start_sync_q <= 3'b111;
      pause_sync_q <= 3'b111;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start_btn_n};
      pause_sync_q <= {pause_sync_q[1:0], pause_btn_n};
    end
  end

  // Press pulses, hit decode and the phase-accumulator step decision
  always_comb begin
    start_p  = start_sync_q[2] & ~start_sync_q[1];
    pause_p  = pause_sync_q[2] & ~pause_sync_q[1];
    hit      = self_hit | wall_hit;
    rate     = BASE_HZ + 32'(level_q) * STEP_HZ;
    acc_sum  = acc_q + rate;
    running  = (state_q == StRun) || (state_q == StDying);
    step     = running && (acc_sum >= CLK_HZ);
    acc_next = step ? (acc_sum - CLK_HZ) : acc_sum;
  end

  // Game state machine with registered pulses, lives, level and accumulator
  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      lives_q         <= LivesInit;
      level_q         <= '0;
      eat_cnt_q       <= '0;
      death_cnt_q     <= '0;
      acc_q           <= '0;
      tick_run_q      <= 1'b0;
      game_reset_q    <= 1'b0;
      round_restart_q <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      // Steps taken while dying freeze the snake instead of moving it
      tick_run_q      <= step && (state_q == StRun);
      game_reset_q    <= 1'b0;
      round_restart_q <= 1'b0;
      if (running) begin
        acc_q <= acc_next;
      end

      unique case (state_q)
        StIdle: begin
          if (start_p) begin
            game_reset_q <= 1'b1;
            acc_q        <= '0;
            lives_q      <= LivesInit;
            level_q      <= '0;
            eat_cnt_q    <= '0;
            state_q      <= StRun;
          end
        end

        StRun: begin
          if (hit) begin
            if (lives_q > 3'd1) begin
              lives_q     <= lives_q - 3'd1;
              death_cnt_q <= '0;
              state_q     <= StDying;
            end else begin
              lives_q     <= '0;
              game_over_q <= 1'b1;
              state_q     <= StOver;
            end
          end else if (pause_p) begin
            state_q <= StPause;
          end else if (eat_evt) begin
            if (eat_cnt_q == EatTop - 1'b1) begin
              eat_cnt_q <= '0;
              if (level_q < LevelTop) begin
                level_q <= level_q + 1'b1;
              end
            end else begin
              eat_cnt_q <= eat_cnt_q + 1'b1;
            end
          end
        end

        StPause: begin
          if (pause_p) begin
            state_q <= StRun;
          end
        end

        StDying: begin
          if (step) begin
            if (death_cnt_q == DieTop - 1'b1) begin
              round_restart_q <= 1'b1;
              acc_q           <= '0;
              state_q         <= StRun;
            end else begin
              death_cnt_q <= death_cnt_q + 1'b1;
            end
          end
        end

        StOver: begin
          if (start_p) begin
            game_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
            acc_q        <= '0;
            lives_q      <= LivesInit;
            level_q      <= '0;
            eat_cnt_q    <= '0;
            state_q      <= StRun;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tick_run      = tick_run_q;
  assign game_reset    = game_reset_q;
  assign round_restart = round_restart_q;
  assign state         = state_q;
  assign lives_left    = lives_q;
  assign level         = level_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: expected pulses (kind, cycle) are queued
// as stimulus is driven and matched against the pulses the DUT produces.
module tb_game_flow_ctrl;

  localparam int KTick = 0;
  localparam int KGr   = 1;
  localparam int KRr   = 2;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_btn_n;
  logic       pause_btn_n;
  logic       eat_evt;
  logic       self_hit;
  logic       wall_hit;
  logic       tick_run;
  logic       game_reset;
  logic       round_restart;
  logic [2:0] state;
  logic [2:0] lives_left;
  logic [3:0] level;
  logic       game_over;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   g;
  exp_t sb[$];

  game_flow_ctrl #(
    .CLK_HZ          (100),
    .BASE_HZ         (10),
    .STEP_HZ         (5),
    .MAX_HZ          (20),
    .POINTS_PER_LEVEL(2),
    .LIVES           (2),
    .DEATH_STEPS     (3),
    .LEVEL_W         (4)
  ) dut (
    .clk_pix      (clk),
    .reset_n      (reset_n),
    .start_btn_n  (start_btn_n),
    .pause_btn_n  (pause_btn_n),
    .eat_evt      (eat_evt),
    .self_hit     (self_hit),
    .wall_hit     (wall_hit),
    .tick_run     (tick_run),
    .game_reset   (game_reset),
    .round_restart(round_restart),
    .state        (state),
    .lives_left   (lives_left),
    .level        (level),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic check_pulse(input int kind);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      e.kind = -1;
      e.cyc  = -1;
    end else begin
      e = sb.pop_front();
    end
    assert ((kind === e.kind) && (cyc === e.cyc)) else begin
      errors++;
      $error("FAIL pulse: observed kind %0d at cycle %0d expected kind %0d at cycle %0d",
             kind, cyc, e.kind, e.cyc);
    end
  endtask

  // Returns 2 time units after the posedge that brings cyc to c
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_lives"}, 32'(lives_left), 2);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_tick"}, 32'(tick_run), 0);
    chk({tag, "_greset"}, 32'(game_reset), 0);
    chk({tag, "_rrestart"}, 32'(round_restart), 0);
    chk({tag, "_over"}, 32'(game_over), 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    start_btn_n = 1'b1;
    pause_btn_n = 1'b1;
    eat_evt     = 1'b0;
    self_hit    = 1'b0;
    wall_hit    = 1'b0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (tick_run === 1'b1) check_pulse(KTick);
        if (game_reset === 1'b1) check_pulse(KGr);
        if (round_restart === 1'b1) check_pulse(KRr);
      end
    join_none

    @(posedge clk);
    #2;
    chk_idle_outputs("in_reset");
    wait_until(3);
    reset_n = 1'b1;

    // Start press: pulse 3 cycles after the pin falls, then level-0 ticks every 10
    wait_until(5);
    start_btn_n = 1'b0;
    g = 8;
    push(KGr, g);
    push(KTick, g + 10);
    push(KTick, g + 20);
    push(KTick, g + 30);
    wait_until(g + 1);
    chk("run_state", 32'(state), 1);
    chk("run_lives", 32'(lives_left), 2);
    chk("run_level", 32'(level), 0);
    chk("run_over", 32'(game_over), 0);
    wait_until(g + 5);
    start_btn_n = 1'b1;

    // Two eats, the second on a tick with an empty accumulator: level 1, 7/7/6
    wait_until(g + 14);
    eat_evt = 1'b1;
    wait_until(g + 15);
    eat_evt = 1'b0;
    wait_until(g + 29);
    eat_evt = 1'b1;
    push(KTick, g + 37);
    push(KTick, g + 44);
    push(KTick, g + 50);
    wait_until(g + 30);
    eat_evt = 1'b0;
    wait_until(g + 31);
    chk("level_1", 32'(level), 1);

    // Eats three and four: level 2, interval 5
    wait_until(g + 39);
    eat_evt = 1'b1;
    wait_until(g + 40);
    eat_evt = 1'b0;
    wait_until(g + 49);
    eat_evt = 1'b1;
    push(KTick, g + 55);
    push(KTick, g + 60);
    push(KTick, g + 65);
    push(KTick, g + 70);
    push(KTick, g + 75);
    wait_until(g + 50);
    eat_evt = 1'b0;
    wait_until(g + 51);
    chk("level_2", 32'(level), 2);

    // Eats five and six: level saturates at 2
    wait_until(g + 56);
    eat_evt = 1'b1;
    wait_until(g + 57);
    eat_evt = 1'b0;
    wait_until(g + 64);
    eat_evt = 1'b1;
    wait_until(g + 65);
    eat_evt = 1'b0;
    wait_until(g + 66);
    chk("level_sat", 32'(level), 2);

    // Pause with 40 in the accumulator; resume leaves a 3-cycle interval
    wait_until(g + 74);
    pause_btn_n = 1'b0;
    wait_until(g + 78);
    chk("pause_state", 32'(state), 2);
    wait_until(g + 82);
    pause_btn_n = 1'b1;
    wait_until(g + 100);
    pause_btn_n = 1'b0;
    push(KTick, g + 106);
    wait_until(g + 103);
    chk("resume_state", 32'(state), 1);
    wait_until(g + 104);
    pause_btn_n = 1'b1;

    // Self hit with a simultaneous eat: lose a life, freeze 3 steps, respawn
    wait_until(g + 107);
    self_hit = 1'b1;
    eat_evt  = 1'b1;
    push(KRr, g + 121);
    push(KTick, g + 126);
    wait_until(g + 108);
    self_hit = 1'b0;
    eat_evt  = 1'b0;
    wait_until(g + 109);
    chk("dying_state", 32'(state), 3);
    chk("dying_lives", 32'(lives_left), 1);
    wait_until(g + 122);
    chk("respawn_state", 32'(state), 1);
    chk("respawn_level", 32'(level), 2);

    // Last life lost on a wall hit: game over, no ticks
    wait_until(g + 127);
    wall_hit = 1'b1;
    wait_until(g + 128);
    wall_hit = 1'b0;
    wait_until(g + 129);
    chk("over_state", 32'(state), 4);
    chk("over_flag", 32'(game_over), 1);
    chk("over_lives", 32'(lives_left), 0);

    // Restart from OVER, then reach level 1 again before the reset test
    wait_until(g + 140);
    start_btn_n = 1'b0;
    push(KGr, g + 143);
    push(KTick, g + 151);
    push(KTick, g + 158);
    wait_until(g + 144);
    chk("restart_state", 32'(state), 1);
    chk("restart_lives", 32'(lives_left), 2);
    chk("restart_level", 32'(level), 0);
    chk("restart_over", 32'(game_over), 0);
    eat_evt = 1'b1;
    wait_until(g + 145);
    eat_evt     = 1'b0;
    start_btn_n = 1'b1;
    wait_until(g + 146);
    eat_evt = 1'b1;
    wait_until(g + 147);
    eat_evt = 1'b0;
    wait_until(g + 148);
    chk("relevel_1", 32'(level), 1);

    // Asynchronous reset mid-cycle in RUN
    wait_until(g + 160);
    #1;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    wait_until(g + 163);
    reset_n = 1'b1;
    wait_until(g + 190);
    chk("post_reset_state", 32'(state), 0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
